// File: rtl/mul_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_ctrl_pkg
//
// Shared definitions for the temporal-PE controllers of the 8-bit systolic
// array. It holds the controller state encoding, the default operand width,
// the default temporal window length and a helper that sizes window counters.
//
// No ports (package).
// Optional build macro used by the controllers that import this package:
//   ZERO_SKIP_EN - skip the temporal window when either operand is zero.
// ---------------------------------------------------------------------------
package mul_ctrl_pkg;

    // Controller states. IDLE waits for operands, LOAD pulses the multiplier
    // init strobe, RUN integrates the output bitstream over the window, DONE
    // holds the product until it is taken and CLEAR pulses the clear strobe.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        CLEAR = 3'd4
    } ctrl_state_e;

    // Operand format width; magnitudes carry one bit less than this.
    localparam int DEFAULT_WIDTH = 8;

    // One full temporal window covers every magnitude code of a WIDTH-1 bit
    // operand.
    localparam int DEFAULT_WIN_LEN = 2 ** (DEFAULT_WIDTH - 1);

    // Width of a window counter. The counter normally matches the operand
    // format width, but it is never allowed to be too narrow to reach the
    // last window index of the requested window length.
    function automatic int winCntWidth(input int width, input int winLen);
        int need;
        need = $clog2(winLen + 1);
        return (width > need) ? width : need;
    endfunction

endpackage

// File: rtl/win_cnt.sv
// ---------------------------------------------------------------------------
// win_cnt
//
// Window counter shared by the temporal-PE controllers. It counts enabled
// cycles from 0 up to WIN_LEN-1, flags the last index of the window and
// wraps back to 0 when it advances past that last index.
//
// Parameters:
//   WIDTH   - counter width in bits.
//   WIN_LEN - window length in cycles (1 .. 2**WIDTH).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   clr_i  in   synchronous clear to 0 (wins over en_i)
//   en_i   in   advance the count by one
//   tc_o   out  count is at the last window index (WIN_LEN-1)
// ---------------------------------------------------------------------------
module win_cnt
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int WIN_LEN = DEFAULT_WIN_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(WIN_LEN - 1);

    logic [WIDTH-1:0] countQ;
    logic [WIDTH-1:0] countD;

    // Next count: a clear always returns to the start of the window, and an
    // enabled count on the last index wraps to 0 so the counter is already
    // at the start when the owner leaves its run state.
    always_comb begin
        countD = countQ;
        if (clr_i) begin
            countD = '0;
        end else if (en_i) begin
            if (countQ == LAST_IDX) begin
                countD = '0;
            end else begin
                countD = countQ + WIDTH'(1);
            end
        end
    end

    // Count register, returned to 0 by the shared asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    // The terminal flag is decoded straight from the register so the owner
    // sees it in the same cycle the last window index is being processed.
    assign tc_o = (countQ == LAST_IDX);

endmodule

// File: rtl/mul_border_ctrl.sv
// ---------------------------------------------------------------------------
// mul_border_ctrl
//
// Sequencer for one unary-temporal border multiplier (mul_border). It takes
// an operand pair over a valid/ready handshake, loads the multiplier, lets
// it run for one full temporal window of WIN_LEN cycles while counting the
// ones on its output bitstream, and returns that count as the product over a
// second valid/ready handshake. The multiplier is cleared after every
// operation, whether it completed or was aborted.
//
// Parameters:
//   WIDTH   - operand format width; magnitudes are WIDTH-1 bits.
//   WIN_LEN - temporal window length in cycles (1 .. 2**(WIDTH-1)).
//
// Build macro:
//   ZERO_SKIP_EN - when defined, a zero operand skips the window and the
//                  product 0 is presented straight after the load cycle.
//                  When undefined the full window always runs.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   operand pair valid
//   in_ready    out  controller can accept an operand pair
//   in_data_i   in   activation magnitude (WIDTH-1)
//   in_data_w   in   weight magnitude (WIDTH-1)
//   abort       in   cancel the operation in LOAD or RUN
//   mul_init    out  one-cycle load strobe to the multiplier
//   mul_clr     out  one-cycle clear strobe to the multiplier
//   mul_data_i  out  registered activation to the multiplier (WIDTH-1)
//   mul_data_w  out  registered weight to the multiplier (WIDTH-1)
//   mul_bit     in   multiplier output bit
//   out_valid   out  product valid
//   out_ready   in   consumer accepts the product
//   out_prod    out  popcount of mul_bit over the window (WIDTH)
//   busy        out  high in every state except IDLE
// ---------------------------------------------------------------------------
module mul_border_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int WIN_LEN = 2 ** (WIDTH - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-2:0] in_data_i,
    input  logic [WIDTH-2:0] in_data_w,
    input  logic             abort,
    output logic             mul_init,
    output logic             mul_clr,
    output logic [WIDTH-2:0] mul_data_i,
    output logic [WIDTH-2:0] mul_data_w,
    input  logic             mul_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prod,
    output logic             busy
);

    localparam int CNT_W = winCntWidth(WIDTH, WIN_LEN);

    ctrl_state_e      stateQ;
    logic             inReadyQ;
    logic             busyQ;
    logic             mulInitQ;
    logic             mulClrQ;
    logic [WIDTH-2:0] mulDataIQ;
    logic [WIDTH-2:0] mulDataWQ;
    logic             outValidQ;
    logic [WIDTH-1:0] outProdQ;
    logic [WIDTH-1:0] accQ;
    logic [WIDTH-1:0] accD;

    logic             cntClr;
    logic             cntEn;
    logic             winLast;

    // Accumulator value after folding in this cycle's multiplier bit. The
    // window never holds more ones than WIN_LEN <= 2**(WIDTH-1), so a
    // WIDTH-bit accumulator cannot overflow.
    assign accD = accQ + WIDTH'(mul_bit);

    // The window counter restarts in LOAD and also on an abort in RUN, so a
    // cancelled window never leaves a partial count behind. It only advances
    // on RUN cycles whose bit is actually accumulated.
    assign cntClr = (stateQ == LOAD) || ((stateQ == RUN) && abort);
    assign cntEn  = (stateQ == RUN) && !abort;

    win_cnt #(
        .WIDTH   (CNT_W),
        .WIN_LEN (WIN_LEN)
    ) u_win_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cntClr),
        .en_i  (cntEn),
        .tc_o  (winLast)
    );

    // Main sequencer. Every output is a register that is updated together
    // with the state transition that implies it, so the strobes and the
    // handshake signals line up exactly with the state they belong to and no
    // output depends combinationally on an input. The init and clear strobes
    // default low each cycle and are only raised on entry to LOAD and CLEAR
    // respectively, which keeps them one cycle wide and never simultaneous.
    // A reset mid-operation drops straight back to idle without a clear
    // pulse because the multiplier shares the same reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            inReadyQ  <= 1'b1;
            busyQ     <= 1'b0;
            mulInitQ  <= 1'b0;
            mulClrQ   <= 1'b0;
            mulDataIQ <= '0;
            mulDataWQ <= '0;
            outValidQ <= 1'b0;
            outProdQ  <= '0;
            accQ      <= '0;
        end else begin
            mulInitQ <= 1'b0;
            mulClrQ  <= 1'b0;

            case (stateQ)
                IDLE: begin
                    if (in_valid) begin
                        mulDataIQ <= in_data_i;
                        mulDataWQ <= in_data_w;
                        inReadyQ  <= 1'b0;
                        busyQ     <= 1'b1;
                        mulInitQ  <= 1'b1;
                        stateQ    <= LOAD;
                    end
                end

                LOAD: begin
                    accQ <= '0;
                    if (abort) begin
                        mulClrQ <= 1'b1;
                        stateQ  <= CLEAR;
                    end
`ifdef ZERO_SKIP_EN
                    else if ((mulDataIQ == '0) || (mulDataWQ == '0)) begin
                        outProdQ  <= '0;
                        outValidQ <= 1'b1;
                        stateQ    <= DONE;
                    end
`endif
                    else begin
                        stateQ <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        accQ    <= '0;
                        mulClrQ <= 1'b1;
                        stateQ  <= CLEAR;
                    end else begin
                        accQ <= accD;
                        if (winLast) begin
                            outProdQ  <= accD;
                            outValidQ <= 1'b1;
                            stateQ    <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        outValidQ <= 1'b0;
                        mulClrQ   <= 1'b1;
                        stateQ    <= CLEAR;
                    end
                end

                CLEAR: begin
                    accQ     <= '0;
                    outProdQ <= '0;
                    inReadyQ <= 1'b1;
                    busyQ    <= 1'b0;
                    stateQ   <= IDLE;
                end

                default: begin
                    accQ      <= '0;
                    outProdQ  <= '0;
                    outValidQ <= 1'b0;
                    inReadyQ  <= 1'b1;
                    busyQ     <= 1'b0;
                    stateQ    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = inReadyQ;
    assign busy       = busyQ;
    assign mul_init   = mulInitQ;
    assign mul_clr    = mulClrQ;
    assign mul_data_i = mulDataIQ;
    assign mul_data_w = mulDataWQ;
    assign out_valid  = outValidQ;
    assign out_prod   = outProdQ;

endmodule

// File: tb/tb_mul_border_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_border_ctrl
//
// Self-checking bench for mul_border_ctrl. The bench plays the part of the
// multiplier: for each operation it builds the bitstream the multiplier
// would emit over the window (a fixed number of ones placed at random
// positions) and drives it cycle by cycle, with random junk on mul_bit
// outside the window. The expected product is the number of ones in that
// window, pushed into a queue when the operands are offered; a separate
// monitor pops and compares whenever the controller presents a product.
// Define ZERO_SKIP_EN for both bench and design to cover that build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_border_ctrl;

    localparam int WIDTH   = 8;
    localparam int WIN_LEN = 2 ** (WIDTH - 1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-2:0] in_data_i = '0;
    logic [WIDTH-2:0] in_data_w = '0;
    logic             abort     = 1'b0;
    logic             mul_init;
    logic             mul_clr;
    logic [WIDTH-2:0] mul_data_i;
    logic [WIDTH-2:0] mul_data_w;
    logic             mul_bit   = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_prod;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit bpHold = 1'b0;

    typedef struct {
        int prod;
        int accCyc;
        int lat;
    } exp_t;

    exp_t sbQ[$];

    mul_border_ctrl #(
        .WIDTH   (WIDTH),
        .WIN_LEN (WIN_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data_i  (in_data_i),
        .in_data_w  (in_data_w),
        .abort      (abort),
        .mul_init   (mul_init),
        .mul_clr    (mul_clr),
        .mul_data_i (mul_data_i),
        .mul_data_w (mul_data_w),
        .mul_bit    (mul_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod),
        .busy       (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Free-running cycle count, used to measure latency in whole cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: accepts products with random backpressure, or refuses them
    // outright while a test holds it off.
    always @(posedge clk) begin
        #1;
        out_ready = bpHold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Safety net so the bench always ends even if the design locks up.
    initial begin
        #(1_000_000);
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Multiplier stub bitstream: exactly n ones scattered over the window.
    function automatic bit [WIN_LEN-1:0] makePattern(input int n);
        bit [WIN_LEN-1:0] p;
        bit               t;
        int               j;
        p = '0;
        for (int i = 0; i < n; i++) p[i] = 1'b1;
        for (int i = WIN_LEN - 1; i > 0; i--) begin
            j    = $urandom_range(0, i);
            t    = p[i];
            p[i] = p[j];
            p[j] = t;
        end
        return p;
    endfunction

    // Reference unary multiplier: the window carries floor(i*w / WIN_LEN)
    // ones, so a zero operand yields an empty bitstream.
    function automatic int refProduct(input int di, input int dw);
        return (di * dw) / WIN_LEN;
    endfunction

    // Offer one operand pair, then drive the multiplier bitstream for its
    // window. abortAt >= 0 raises abort on that window cycle and checks the
    // cancellation; otherwise the expected product goes into the scoreboard.
    task automatic applyStimulus(input logic [WIDTH-2:0] di, input logic [WIDTH-2:0] dw,
                                 input bit [WIN_LEN-1:0] pat, input int expProd,
                                 input int abortAt, input bit junkOne);
        int   waitCyc;
        int   accCyc;
        bit   zeroSkip;
        exp_t e;

`ifdef ZERO_SKIP_EN
        zeroSkip = (di == '0) || (dw == '0);
`else
        zeroSkip = 1'b0;
`endif
        waitCyc = 0;
        @(negedge clk);
        in_data_i = di;
        in_data_w = dw;
        in_valid  = 1'b1;
        mul_bit   = junkOne ? 1'b1 : 1'($urandom_range(0, 1));
        while (!in_ready && waitCyc < 400) begin
            @(negedge clk);
            mul_bit = junkOne ? 1'b1 : 1'($urandom_range(0, 1));
            waitCyc++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end

        accCyc = cyc + 1;
        if (abortAt < 0) begin
            e.prod   = zeroSkip ? 0 : expProd;
            e.accCyc = accCyc;
            e.lat    = zeroSkip ? 1 : 1 + WIN_LEN;
            sbQ.push_back(e);
        end

        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data_i = WIDTH'($urandom);
        in_data_w = WIDTH'($urandom);
        mul_bit   = junkOne ? 1'b1 : 1'($urandom_range(0, 1));

        @(negedge clk);
        checkOutput("load_mul_init", mul_init, 1);
        checkOutput("load_mul_data_i", mul_data_i, di);
        checkOutput("load_mul_data_w", mul_data_w, dw);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_in_ready", in_ready, 0);
        if (zeroSkip) return;

        for (int k = 0; k < WIN_LEN; k++) begin
            @(posedge clk);
            #1;
            mul_bit = pat[k];
            abort   = (k == abortAt);
            if (k == 0) checkOutput("run_mul_init_low", mul_init, 0);
            if (k == abortAt) begin
                @(posedge clk);
                #1;
                abort   = 1'b0;
                mul_bit = junkOne ? 1'b1 : 1'($urandom_range(0, 1));
                checkOutput("abort_mul_clr", mul_clr, 1);
                checkOutput("abort_out_valid", out_valid, 0);
                @(posedge clk);
                #1;
                checkOutput("abort_idle_busy", busy, 0);
                checkOutput("abort_idle_in_ready", in_ready, 1);
                checkOutput("abort_clr_once", mul_clr, 0);
                return;
            end
        end
        @(posedge clk);
        #1;
        mul_bit = junkOne ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((sbQ.size() != 0 || busy || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("idle_timeout", 0, 1);
    endtask

    // Monitor: compares each presented product against the scoreboard head,
    // checks it stays stable under backpressure, and follows the hand-off
    // through the clear pulse back to idle.
    exp_t cur;
    bit   seen     = 1'b0;
    bit   clrPend  = 1'b0;
    bit   idlePend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            seen     = 1'b0;
            clrPend  = 1'b0;
            idlePend = 1'b0;
        end else begin
            checkOutput("init_clr_exclusive", int'(mul_init & mul_clr), 0);
            if (out_valid) begin
                if (!seen) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_out_valid", 1, 0);
                    end else begin
                        cur  = sbQ.pop_front();
                        seen = 1'b1;
                        checkOutput("latency", cyc - cur.accCyc, cur.lat);
                        checkOutput("out_prod", out_prod, cur.prod);
                    end
                end else begin
                    checkOutput("out_prod_stable", out_prod, cur.prod);
                end
                checkOutput("done_in_ready", in_ready, 0);
                if (out_ready && seen) begin
                    seen    = 1'b0;
                    clrPend = 1'b1;
                end
            end else if (clrPend) begin
                checkOutput("mul_clr_after_accept", mul_clr, 1);
                clrPend  = 1'b0;
                idlePend = 1'b1;
            end else if (idlePend) begin
                checkOutput("idle_busy", busy, 0);
                checkOutput("idle_in_ready", in_ready, 1);
                idlePend = 1'b0;
            end
        end
    end

    // Test sequence.
    initial begin
        bit [WIN_LEN-1:0] pat;
        logic [WIDTH-2:0] di;
        logic [WIDTH-2:0] dw;
        int               n;
        int               waitCyc;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_mul_init", mul_init, 0);
        checkOutput("reset_mul_clr", mul_clr, 0);
        checkOutput("reset_out_prod", out_prod, 0);
        rst = 1'b0;

        $display("[TB] basic product, 37 ones");
        pat = makePattern(37);
        applyStimulus(7'd100, 7'd50, pat, 37, -1, 1'b0);
        waitIdle(400);

        $display("[TB] backpressure in DONE");
        bpHold = 1'b1;
        pat = makePattern(37);
        applyStimulus(7'd100, 7'd50, pat, 37, -1, 1'b0);
        waitCyc = 0;
        @(negedge clk);
        while (!out_valid && waitCyc < 400) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("bp_out_valid_seen", out_valid, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid_held", out_valid, 1);
            checkOutput("bp_out_prod_held", out_prod, 37);
            checkOutput("bp_mul_data_i_kept", mul_data_i, 100);
            in_valid  = k[0];
            in_data_i = 7'h55;
            in_data_w = 7'h2a;
        end
        in_valid = 1'b0;
        bpHold   = 1'b0;
        waitIdle(400);

        $display("[TB] abort at window cycle 60, then a clean operation");
        pat = makePattern(70);
        applyStimulus(7'd90, 7'd80, pat, 0, 60, 1'b0);
        pat = makePattern(20);
        applyStimulus(7'd30, 7'd40, pat, 20, -1, 1'b0);

        $display("[TB] saturated window");
        pat = '1;
        applyStimulus(7'd127, 7'd127, pat, WIN_LEN, -1, 1'b1);

        $display("[TB] random operands");
        for (int i = 0; i < 6; i++) begin
            di = 7'($urandom_range(0, 127));
            dw = (i % 3 == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            n  = refProduct(int'(di), int'(dw));
            pat = makePattern(n);
            applyStimulus(di, dw, pat, n, -1, 1'b0);
        end

        $display("[TB] reset during RUN");
        waitIdle(1000);
        @(negedge clk);
        in_data_i = 7'd9;
        in_data_w = 7'd9;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset_in_ready", in_ready, 1);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_mul_clr", mul_clr, 0);
        checkOutput("midreset_mul_data_i", mul_data_i, 0);
        checkOutput("midreset_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        pat = makePattern(3);
        applyStimulus(7'd5, 7'd90, pat, 3, -1, 1'b0);
        waitIdle(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
